// File: rtl/lsu_pkg.sv
// Shared state encoding, access-size constants and address helpers for the
// load/store unit and its load aligner.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_A,
        LD_B,
        LD_FIN,
        ST
    } lsu_state_e;

    localparam logic [2:0] SZ_B = 3'd1;
    localparam logic [2:0] SZ_H = 3'd2;
    localparam logic [2:0] SZ_W = 3'd4;

    // Any size other than byte or halfword is a word access.
    function automatic logic [2:0] norm_size(input logic [2:0] size);
        return (size == SZ_B || size == SZ_H) ? size : SZ_W;
    endfunction

    function automatic logic crosses_word(input logic [1:0] offset, input logic [2:0] size);
        return ({2'b00, offset} + {1'b0, size}) > 4'd4;
    endfunction

    // Sizes are powers of two, so addr % size is the offset masked by size-1.
    function automatic logic is_aligned(input logic [1:0] offset, input logic [2:0] size);
        return (offset & (size[1:0] - 2'd1)) == 2'd0;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational load aligner: selects size bytes starting at offset from the
// little-endian pair {w1, w0} and zero- or sign-extends them to 32 bits.
module load_extract
    import lsu_pkg::*;
(
    input  logic [31:0] w0,
    input  logic [31:0] w1,
    input  logic [1:0]  offset,
    input  logic [2:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [31:0] window;

    assign window = 32'({w1, w0} >> {offset, 3'b000});

    always_comb begin
        // NOTE: assign a default before the case so no path leaves result unassigned (no latch).
        result = window;
        case (size)
            SZ_B:    result = {{24{~is_unsigned & window[7]}}, window[7:0]};
            SZ_H:    result = {{16{~is_unsigned & window[15]}}, window[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit driving a synchronous data memory: loads may span two words,
// misaligned stores are split into single-byte writes.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  xfer_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] w0_q;
    logic [2:0]  size_q;
    logic        unsigned_q;
    logic [1:0]  k_q;

    logic        span;
    logic        aligned;
    logic        last_byte;
    logic [31:0] word0;
    logic [31:0] ext_w0;
    logic [31:0] load_result;

    assign word0     = {addr_q[31:2], 2'b00};
    assign span      = crosses_word(addr_q[1:0], size_q);
    assign aligned   = is_aligned(addr_q[1:0], size_q);
    assign last_byte = aligned || (k_q == size_q[1:0] - 2'd1);
    assign req_ready = (state == IDLE);

    // Without a span the only word fetched is the one arriving in LD_FIN.
    assign ext_w0 = span ? w0_q : mem_rdata;

    load_extract u_load_extract (
        .w0          (ext_w0),
        .w1          (mem_rdata),
        .offset      (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .result      (load_result)
    );

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        xfer_size = 3'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        case (state)
            LD_A: begin
                mem_read  = 1'b1;
                xfer_size = SZ_W;
                mem_addr  = word0;
            end
            LD_B: begin
                mem_read  = 1'b1;
                xfer_size = SZ_W;
                mem_addr  = word0 + 32'd4;
            end
            ST: begin
                mem_write = 1'b1;
                if (aligned) begin
                    xfer_size = size_q;
                    mem_addr  = addr_q;
                    mem_wdata = wdata_q;
                end else begin
                    xfer_size = SZ_B;
                    mem_addr  = addr_q + 32'(k_q);
                    mem_wdata = {24'd0, 8'(wdata_q >> {k_q, 3'b000})};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            w0_q       <= 32'd0;
            size_q     <= 3'd0;
            unsigned_q <= 1'b0;
            k_q        <= 2'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        size_q     <= norm_size(req_size);
                        unsigned_q <= req_unsigned;
                        k_q        <= 2'd0;
                        state      <= req_is_store ? ST : LD_A;
                    end
                end
                LD_A: state <= span ? LD_B : LD_FIN;
                LD_B: begin
                    w0_q  <= mem_rdata;
                    state <= LD_FIN;
                end
                LD_FIN: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= load_result;
                    state      <= IDLE;
                end
                ST: begin
                    k_q <= k_q + 2'd1;
                    if (last_byte) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= 32'd0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed memory scenarios plus randomized
// loads/stores checked against a byte-array reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  xfer_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  sz;
        logic [31:0] data;
    } tx_t;

    tx_t txq[$];

    logic [7:0] mem_b [256];
    logic [7:0] ref_b [256];

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .xfer_size    (xfer_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    function automatic logic [7:0] init_byte(input int i);
        logic [63:0] pre;
        pre = 64'hFFEEDDCC_87654321;
        if (i < 8) return pre[8*i +: 8];
        return 8'(i * 37 + 11);
    endfunction

    // Synchronous memory: 256-byte ring, read data one cycle after address.
    initial begin
        logic [7:0] a;
        for (int i = 0; i < 256; i++) mem_b[i] = init_byte(i);
        forever begin
            @(posedge clk);
            a = mem_addr[7:0];
            if (mem_write)
                for (int i = 0; i < 4; i++)
                    if (i < int'(xfer_size)) mem_b[a + 8'(i)] = mem_wdata[8*i +: 8];
            if (mem_read)
                mem_rdata <= {mem_b[a + 8'd3], mem_b[a + 8'd2], mem_b[a + 8'd1], mem_b[a]};
        end
    end

    always @(negedge clk)
        if (rst_n && (mem_read || mem_write))
            txq.push_back(tx_t'{mem_write, mem_addr, xfer_size, mem_wdata});

    // Reference model: plain byte arithmetic on the same 256-byte ring.
    function automatic int model_size(input logic [2:0] s);
        if (s == 3'd1) return 1;
        if (s == 3'd2) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input int n, input bit uns);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_b[8'(addr + 32'(i))]) << (8 * i));
        if (!uns && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic model_store(input logic [31:0] addr, input int n, input logic [31:0] wd);
        for (int i = 0; i < n; i++) ref_b[8'(addr + 32'(i))] = wd[8*i +: 8];
    endtask

    // Issues one request from a negedge; returns at the negedge where resp_valid is seen.
    task automatic run_op(input bit st, input logic [2:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rdata, output int lat,
                          output bit ready_at_resp, output int waited);
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_wait: req_ready=%b required 1", req_ready);
        end
        txq.delete();
        req_valid    = 1'b1;
        req_is_store = st;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_is_store = 1'($urandom);
        req_size     = 3'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
        lat           = 0;
        rdata         = 32'hDEAD_BEEF;
        ready_at_resp = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat           = k;
                rdata         = resp_rdata;
                ready_at_resp = req_ready;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        req_valid    = 1'b1;
        req_is_store = 1'b1;
        req_size     = 3'd4;
        req_unsigned = 1'b0;
        req_addr     = 32'h0000_0010;
        req_wdata    = 32'h1234_5678;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({mem_read, mem_write, resp_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b required 000", {mem_read, mem_write, resp_valid});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, resp_rdata} !== 96'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h required 0", {mem_addr, mem_wdata, resp_rdata});
        end
        n_checks++;
        if (xfer_size !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_xfer_size: got %0d required 0", xfer_size);
        end
        req_valid = 1'b0;
        rst_n     = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b required 1", req_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] r;
        int          lat, w;
        bit          rdy;
        tx_t         exp_tx;
        logic [31:0] word;

        run_op(1'b0, 3'd4, 1'b0, 32'd0, 32'd0, r, lat, rdy, w);
        n_checks++;
        if (r !== 32'h8765_4321) begin n_fail++; $display("FAIL lw0_rdata: got %h required 87654321", r); end
        n_checks++;
        if (lat != 3) begin n_fail++; $display("FAIL lw0_latency: got %0d required 3", lat); end
        n_checks++;
        if (txq.size() != 1 || txq[0].wr !== 1'b0 || txq[0].addr !== 32'd0) begin
            n_fail++;
            $display("FAIL lw0_reads: got %0d cycles first addr %h required 1 read at 0", txq.size(), txq[0].addr);
        end

        run_op(1'b0, 3'd1, 1'b0, 32'd3, 32'd0, r, lat, rdy, w);
        n_checks++;
        if (r !== 32'hFFFF_FF87) begin n_fail++; $display("FAIL lb3_rdata: got %h required ffffff87", r); end
        run_op(1'b0, 3'd1, 1'b1, 32'd3, 32'd0, r, lat, rdy, w);
        n_checks++;
        if (r !== 32'h0000_0087) begin n_fail++; $display("FAIL lbu3_rdata: got %h required 00000087", r); end

        run_op(1'b0, 3'd2, 1'b0, 32'd3, 32'd0, r, lat, rdy, w);
        n_checks++;
        if (r !== 32'hFFFF_CC87) begin n_fail++; $display("FAIL lh3_rdata: got %h required ffffcc87", r); end
        n_checks++;
        if (lat != 4) begin n_fail++; $display("FAIL lh3_latency: got %0d required 4", lat); end
        n_checks++;
        if (txq.size() != 2 || txq[0].addr !== 32'd0 || txq[1].addr !== 32'd4) begin
            n_fail++;
            $display("FAIL lh3_reads: got %0d cycles addrs %h %h required 2 reads at 0 and 4",
                     txq.size(), txq[0].addr, txq[1].addr);
        end

        run_op(1'b0, 3'd4, 1'b0, 32'd2, 32'd0, r, lat, rdy, w);
        n_checks++;
        if (r !== 32'hDDCC_8765) begin n_fail++; $display("FAIL lw2_rdata: got %h required ddcc8765", r); end

        run_op(1'b1, 3'd4, 1'b0, 32'd1, 32'hAABB_CCDD, r, lat, rdy, w);
        model_store(32'd1, 4, 32'hAABB_CCDD);
        n_checks++;
        if (lat != 5) begin n_fail++; $display("FAIL sw1_latency: got %0d required 5", lat); end
        n_checks++;
        if (r !== 32'd0) begin n_fail++; $display("FAIL sw1_rdata: got %h required 0", r); end
        n_checks++;
        if (txq.size() != 4) begin n_fail++; $display("FAIL sw1_count: got %0d required 4", txq.size()); end
        for (int i = 0; i < 4 && i < txq.size(); i++) begin
            word   = 32'hAABB_CCDD >> (8 * i);
            exp_tx = tx_t'{1'b1, 32'd1 + 32'(i), 3'd1, {24'd0, word[7:0]}};
            n_checks++;
            if (txq[i] !== exp_tx) begin
                n_fail++;
                $display("FAIL sw1_write%0d: got %h required %h", i, txq[i], exp_tx);
            end
        end
        word = {mem_b[3], mem_b[2], mem_b[1], mem_b[0]};
        n_checks++;
        if (word !== 32'hBBCC_DD21) begin n_fail++; $display("FAIL sw1_word0: got %h required bbccdd21", word); end
        word = {mem_b[7], mem_b[6], mem_b[5], mem_b[4]};
        n_checks++;
        if (word !== 32'hFFEE_DDAA) begin n_fail++; $display("FAIL sw1_word4: got %h required ffeeddaa", word); end
    endtask

    task automatic test_wrap();
        logic [31:0] r, exp_r, wd;
        int          lat, w;
        bit          rdy;

        exp_r = model_load(32'hFFFF_FFFE, 4, 1'b0);
        run_op(1'b0, 3'd4, 1'b0, 32'hFFFF_FFFE, 32'd0, r, lat, rdy, w);
        n_checks++;
        if (r !== exp_r) begin n_fail++; $display("FAIL wrap_lw_rdata: got %h required %h", r, exp_r); end
        n_checks++;
        if (txq.size() != 2 || txq[0].addr !== 32'hFFFF_FFFC || txq[1].addr !== 32'd0) begin
            n_fail++;
            $display("FAIL wrap_lw_addrs: got %0d cycles addrs %h %h required fffffffc then 0",
                     txq.size(), txq[0].addr, txq[1].addr);
        end

        wd = $urandom;
        run_op(1'b1, 3'd2, 1'b0, 32'hFFFF_FFFF, wd, r, lat, rdy, w);
        model_store(32'hFFFF_FFFF, 2, wd);
        n_checks++;
        if (txq.size() != 2 || txq[0].addr !== 32'hFFFF_FFFF || txq[1].addr !== 32'd0) begin
            n_fail++;
            $display("FAIL wrap_sh_addrs: got %0d cycles addrs %h %h required ffffffff then 0",
                     txq.size(), txq[0].addr, txq[1].addr);
        end
        exp_r = model_load(32'd0, 1, 1'b1);
        run_op(1'b0, 3'd1, 1'b1, 32'd0, 32'd0, r, lat, rdy, w);
        n_checks++;
        if (r !== exp_r) begin n_fail++; $display("FAIL wrap_sh_byte0: got %h required %h", r, exp_r); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, exp_r;
        int          lat, w;
        bit          rdy;

        run_op(1'b0, 3'd1, 1'b1, 32'd9, 32'd0, r, lat, rdy, w);
        n_checks++;
        if (rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_with_resp: got %b required 1", rdy); end
        exp_r = model_load(32'd22, 2, 1'b0);
        run_op(1'b0, 3'd2, 1'b0, 32'd22, 32'd0, r, lat, rdy, w);
        n_checks++;
        if (w != 0) begin n_fail++; $display("FAIL b2b_bubble: got %0d wait cycles required 0", w); end
        n_checks++;
        if (r !== exp_r || lat != 3) begin
            n_fail++;
            $display("FAIL b2b_second: got %h lat %0d required %h lat 3", r, lat, exp_r);
        end
    endtask

    task automatic test_random();
        bit          st, uns, rdy, span, al;
        logic [2:0]  sz;
        logic [31:0] a, wd, r, exp_r;
        int          n, lat, w, exp_lat, exp_tx;

        for (int t = 0; t < 60; t++) begin
            st  = 1'($urandom);
            sz  = 3'($urandom_range(0, 7));
            uns = 1'($urandom);
            wd  = $urandom;
            a   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                              : 32'($urandom_range(0, 63));
            n    = model_size(sz);
            span = (int'(a[1:0]) + n) > 4;
            al   = (int'(a[1:0]) % n) == 0;
            if (st) begin
                exp_r   = 32'd0;
                exp_lat = al ? 2 : n + 1;
                exp_tx  = al ? 1 : n;
            end else begin
                exp_r   = model_load(a, n, uns);
                exp_lat = span ? 4 : 3;
                exp_tx  = span ? 2 : 1;
            end
            run_op(st, sz, uns, a, wd, r, lat, rdy, w);
            if (st) model_store(a, n, wd);
            n_checks++;
            if (r !== exp_r) begin
                n_fail++;
                $display("FAIL rand%0d_rdata: st=%b size=%0d uns=%b addr=%h got %h required %h",
                         t, st, sz, uns, a, r, exp_r);
            end
            n_checks++;
            if (lat != exp_lat) begin
                n_fail++;
                $display("FAIL rand%0d_latency: st=%b size=%0d addr=%h got %0d required %0d",
                         t, st, sz, a, lat, exp_lat);
            end
            n_checks++;
            if (txq.size() != exp_tx || txq[0].wr !== st) begin
                n_fail++;
                $display("FAIL rand%0d_cycles: st=%b size=%0d addr=%h got %0d (wr=%b) required %0d",
                         t, st, sz, a, txq.size(), txq[0].wr, exp_tx);
            end
            if (!st) begin
                n_checks++;
                if (txq[0].addr !== {a[31:2], 2'b00}) begin
                    n_fail++;
                    $display("FAIL rand%0d_load_addr: got %h required %h", t, txq[0].addr, {a[31:2], 2'b00});
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        int          strobes, resps, lat, w;
        bit          rdy;
        logic [31:0] r, exp_r;

        strobes      = 0;
        resps        = 0;
        req_valid    = 1'b1;
        req_is_store = 1'b0;
        req_size     = 3'd2;
        req_unsigned = 1'b0;
        req_addr     = 32'd3;
        req_wdata    = 32'd0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (mem_read !== 1'b1 || mem_addr !== 32'd4) begin
            n_fail++;
            $display("FAIL abort_in_ld_b: got read=%b addr=%h required read=1 addr=4", mem_read, mem_addr);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({mem_read, mem_write, resp_valid} !== 3'b000 || mem_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL abort_strobes: got %b addr %h required 000 addr 0",
                     {mem_read, mem_write, resp_valid}, mem_addr);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b required 1", req_ready); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid) resps++;
            if (mem_read || mem_write) strobes++;
        end
        n_checks++;
        if (resps != 0 || strobes != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: got %0d resp %0d strobe cycles required 0 and 0", resps, strobes);
        end
        exp_r = model_load(32'd4, 4, 1'b0);
        run_op(1'b0, 3'd4, 1'b0, 32'd4, 32'd0, r, lat, rdy, w);
        n_checks++;
        if (r !== exp_r || lat != 3) begin
            n_fail++;
            $display("FAIL abort_recover: got %h lat %0d required %h lat 3", r, lat, exp_r);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_b[i] = init_byte(i);
        test_reset();
        test_directed();
        test_wrap();
        test_back_to_back();
        test_random();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
